pifo_pop_collector: RTL and testbench

- Egress-side companion to the multi-level SRAM PIFO tree top.
- Accepts up to LEVEL pop results per cycle and compacts them in lane order into one shared result FIFO.
- Drains the FIFO as a single valid/ready stream tagged with tree id.
- Tracks outstanding pops per tree and gives pop-issue backpressure, so a result can never be dropped while issuers honour the stall.

---
 rtl/pifo_pop_collector_if.sv | 41 ++++
 rtl/pifo_pop_collector.sv | 170 +++++++++++++++++
 tb/tb_pifo_pop_collector.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pifo_pop_collector_if.sv
// Signal bundle between PIFO pop issuers / result lanes and the pop collector,
// including the egress valid/ready stream and status flags.
interface pifo_pop_collector_if #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int LEVEL     = 4,
    parameter int TREE_NUM  = 4,
    parameter int OUT_DEPTH = 16
);
    localparam int DW  = MTW + PTW;
    localparam int TNB = $clog2(TREE_NUM);
    localparam int CW  = $clog2(OUT_DEPTH) + 1;

    logic [LEVEL-1:0]           i_pop_issue;
    logic [LEVEL-1:0][TNB-1:0]  i_pop_issue_tree_id;
    logic [LEVEL-1:0]           i_is_level0_pop;
    logic [LEVEL-1:0][TNB-1:0]  i_tree_id;
    logic [LEVEL-1:0][DW-1:0]   i_pop_data;
    logic                       o_valid;
    logic                       i_ready;
    logic [DW-1:0]              o_data;
    logic [TNB-1:0]             o_tree_id;
    logic                       o_pop_stall;
    logic                       o_overflow;
    logic                       o_err_unexpected;
    logic [CW-1:0]              o_count;

    modport master (
        output i_pop_issue, i_pop_issue_tree_id, i_is_level0_pop, i_tree_id,
               i_pop_data, i_ready,
        input  o_valid, o_data, o_tree_id, o_pop_stall, o_overflow,
               o_err_unexpected, o_count
    );

    modport slave (
        input  i_pop_issue, i_pop_issue_tree_id, i_is_level0_pop, i_tree_id,
               i_pop_data, i_ready,
        output o_valid, o_data, o_tree_id, o_pop_stall, o_overflow,
               o_err_unexpected, o_count
    );
endinterface

// File: rtl/pifo_pop_collector.sv
// Compacts up to LEVEL pop results per cycle into one result FIFO and tracks
// outstanding pops per tree for issue backpressure. Option: PIFO_COLLECT_EMPTY_FILTER_EN.
module pifo_pop_collector #(
    parameter int PTW       = 16,
    parameter int MTW       = 0,
    parameter int LEVEL     = 4,
    parameter int TREE_NUM  = 4,
    parameter int OUT_DEPTH = 16,
    parameter int OCW       = 5
) (
    input  logic                 i_clk,
    input  logic                 i_arst_n,
    pifo_pop_collector_if.slave  bus
);
    localparam int DW       = MTW + PTW;
    localparam int TNB      = $clog2(TREE_NUM);
    localparam int AW       = $clog2(OUT_DEPTH);
    localparam int CW       = AW + 1;
    localparam int EW       = TNB + DW;
    localparam int LW       = $clog2(LEVEL + 1);
    localparam int NW       = OCW + LW + 1;
    localparam int TW       = OCW + TNB + 1;
    localparam int SW       = CW + TW + 2;
    localparam int OCNT_MAX = (2 ** OCW) - 1;

    logic [LEVEL-1:0]           cap_v_q,  cap_v_d;
    logic [LEVEL-1:0][TNB-1:0]  cap_id_q, cap_id_d;
    logic [LEVEL-1:0][DW-1:0]   cap_d_q,  cap_d_d;
    logic [EW-1:0]              mem_q [OUT_DEPTH];
    logic [EW-1:0]              mem_d [OUT_DEPTH];
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]              count_q,  count_d;
    logic [EW-1:0]              head_q,   head_d;
    logic [OCW-1:0]             outst_q [TREE_NUM];
    logic [OCW-1:0]             outst_d [TREE_NUM];
    logic [TW-1:0]              tot_q,    tot_d;
    logic                       stall_q,  stall_d;
    logic                       overflow_q, overflow_d;
    logic                       err_q,    err_d;

    logic [LEVEL-1:0]           wr_mask;
    logic                       rd_en;
    logic [CW-1:0]              free;
    logic [CW-1:0]              n_wr;
    logic                       drop;
    logic [LW-1:0]              inc;
    logic [LW-1:0]              dec;
    logic [NW-1:0]              base;
    logic [NW-1:0]              diff;

    always_comb begin
        cap_v_d  = bus.i_is_level0_pop;
        cap_id_d = bus.i_tree_id;
        cap_d_d  = bus.i_pop_data;

        wr_mask = cap_v_q;
`ifdef PIFO_COLLECT_EMPTY_FILTER_EN
        for (int k = 0; k < LEVEL; k++) begin
            if (cap_d_q[k] == {DW{1'b1}}) begin
                wr_mask[k] = 1'b0;
            end
        end
`endif

        rd_en = (count_q != '0) && bus.i_ready;
        free  = CW'(OUT_DEPTH) - count_q + CW'(rd_en);

        // Once one lane fails to fit, every higher lane fails too, so this
        // keeps the lowest-indexed lanes and packs them contiguously.
        mem_d = mem_q;
        n_wr  = '0;
        drop  = 1'b0;
        for (int k = 0; k < LEVEL; k++) begin
            if (wr_mask[k]) begin
                if (n_wr < free) begin
                    mem_d[wr_ptr_q + AW'(n_wr)] = {cap_id_q[k], cap_d_q[k]};
                    n_wr = n_wr + CW'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end

        wr_ptr_d   = wr_ptr_q + AW'(n_wr);
        rd_ptr_d   = rd_ptr_q + AW'(rd_en);
        count_d    = count_q + n_wr - CW'(rd_en);
        head_d     = mem_d[rd_ptr_d];
        overflow_d = overflow_q | drop;
    end

    always_comb begin
        err_d   = err_q;
        tot_d   = tot_q;
        outst_d = outst_q;
        inc     = '0;
        dec     = '0;
        base    = '0;
        diff    = '0;
        for (int t = 0; t < TREE_NUM; t++) begin
            inc = '0;
            dec = '0;
            for (int k = 0; k < LEVEL; k++) begin
                if (bus.i_pop_issue[k] && (bus.i_pop_issue_tree_id[k] == TNB'(t))) begin
                    inc = inc + LW'(1);
                end
                if (cap_v_q[k] && (cap_id_q[k] == TNB'(t))) begin
                    dec = dec + LW'(1);
                end
            end
            base = NW'(outst_q[t]) + NW'(inc);
            if (NW'(dec) > base) begin
                diff  = '0;
                err_d = 1'b1;
            end else begin
                diff = base - NW'(dec);
            end
            if (diff > NW'(OCNT_MAX)) begin
                diff = NW'(OCNT_MAX);
            end
            outst_d[t] = OCW'(diff);
            tot_d      = tot_d + TW'(outst_d[t]) - TW'(outst_q[t]);
        end
        stall_d = (SW'(OUT_DEPTH) - SW'(count_d)) < (SW'(tot_d) + SW'(LEVEL));
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
        if (!i_arst_n) begin
            cap_v_q    <= '0;
            cap_id_q   <= '0;
            cap_d_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            head_q     <= '0;
            tot_q      <= '0;
            stall_q    <= 1'b0;
            overflow_q <= 1'b0;
            err_q      <= 1'b0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            for (int t = 0; t < TREE_NUM; t++) begin
                outst_q[t] <= '0;
            end
        end else begin
            cap_v_q    <= cap_v_d;
            cap_id_q   <= cap_id_d;
            cap_d_q    <= cap_d_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
            tot_q      <= tot_d;
            stall_q    <= stall_d;
            overflow_q <= overflow_d;
            err_q      <= err_d;
            mem_q      <= mem_d;
            outst_q    <= outst_d;
        end
    end

    assign bus.o_valid          = (count_q != '0);
    assign bus.o_data           = head_q[DW-1:0];
    assign bus.o_tree_id        = head_q[EW-1:DW];
    assign bus.o_count          = count_q;
    assign bus.o_pop_stall      = stall_q;
    assign bus.o_overflow       = overflow_q;
    assign bus.o_err_unexpected = err_q;
endmodule

// File: tb/tb_pifo_pop_collector.sv
// Directed, table-driven bench for pifo_pop_collector (default parameters),
// with hand-written sequences for backpressure, overflow and reset corners.
module tb_pifo_pop_collector;
    localparam int LEVEL = 4;
    localparam int NROWS = 20;

    typedef struct {
        logic [3:0]       issue;
        logic [3:0][1:0]  issueId;
        logic [3:0]       lvl0;
        logic [3:0][1:0]  resId;
        logic [3:0][15:0] resData;
        logic             ready;
        logic             expValid;
        logic [15:0]      expData;
        logic [1:0]       expTree;
        logic             expStall;
        logic             expOverflow;
        logic             expErr;
        logic [4:0]       expCount;
    } vec_t;

    logic clock;
    logic arstN;
    int   testsRun;
    int   testsFailed;
    vec_t vecs [NROWS];

    pifo_pop_collector_if bus ();

    pifo_pop_collector dut (
        .i_clk    (clock),
        .i_arst_n (arstN),
        .bus      (bus)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic clearInputs();
        bus.i_pop_issue         = '0;
        bus.i_pop_issue_tree_id = '0;
        bus.i_is_level0_pop     = '0;
        bus.i_tree_id           = '0;
        bus.i_pop_data          = '0;
    endtask

    task automatic doReset();
        clearInputs();
        bus.i_ready = 1'b0;
        arstN = 1'b0;
        step();
        step();
        arstN = 1'b1;
    endtask

    task automatic setVec(input int idx, input logic [3:0] issue, input logic [7:0] issueId,
                          input logic [3:0] lvl0, input logic [7:0] resId,
                          input logic [63:0] resData, input logic ev, input logic [15:0] ed,
                          input logic [1:0] et, input logic ee, input logic [4:0] ec);
        vecs[idx].issue       = issue;
        vecs[idx].issueId     = issueId;
        vecs[idx].lvl0        = lvl0;
        vecs[idx].resId       = resId;
        vecs[idx].resData     = resData;
        vecs[idx].ready       = 1'b1;
        vecs[idx].expValid    = ev;
        vecs[idx].expData     = ed;
        vecs[idx].expTree     = et;
        vecs[idx].expStall    = 1'b0;
        vecs[idx].expOverflow = 1'b0;
        vecs[idx].expErr      = ee;
        vecs[idx].expCount    = ec;
    endtask

    task automatic applyStimulus(input vec_t v);
        bus.i_pop_issue         = v.issue;
        bus.i_pop_issue_tree_id = v.issueId;
        bus.i_is_level0_pop     = v.lvl0;
        bus.i_tree_id           = v.resId;
        bus.i_pop_data          = v.resData;
        bus.i_ready             = v.ready;
        step();
    endtask

    task automatic pushResults(input logic [3:0] mask, input logic [1:0] tree,
                               input logic [15:0] baseData);
        bus.i_is_level0_pop = mask;
        for (int k = 0; k < LEVEL; k++) begin
            bus.i_tree_id[k]  = tree;
            bus.i_pop_data[k] = baseData + 16'(k);
        end
        step();
        clearInputs();
    endtask

    task automatic checkFlags(input string tag, input logic v, input logic [4:0] c,
                              input logic s, input logic o, input logic e);
        checkOutput({tag, " valid"},    32'(bus.o_valid),          32'(v));
        checkOutput({tag, " count"},    32'(bus.o_count),          32'(c));
        checkOutput({tag, " stall"},    32'(bus.o_pop_stall),      32'(s));
        checkOutput({tag, " overflow"}, 32'(bus.o_overflow),       32'(o));
        checkOutput({tag, " err"},      32'(bus.o_err_unexpected), 32'(e));
    endtask

    initial begin
        logic [15:0] expHead;
        testsRun    = 0;
        testsFailed = 0;
        arstN       = 1'b0;
        bus.i_ready = 1'b0;
        clearInputs();
        step();
        step();
        checkFlags("reset", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("reset data", 32'(bus.o_data), 32'h0);
        checkOutput("reset tree", 32'(bus.o_tree_id), 32'h0);
        arstN = 1'b1;

        // Single result, compaction of lanes 1/3, unexpected result, all-ones data.
        setVec(0,  4'b0001, 8'h02, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        for (int i = 1; i <= 4; i++) begin
            setVec(i, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        end
        setVec(5,  4'b0000, 8'h00, 4'b0100, 8'h20, 64'h0000_0034_0000_0000,
               1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(6,  4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 16'h0034, 2'd2, 1'b0, 5'd1);
        setVec(7,  4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(8,  4'b0011, 8'h05, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(9,  4'b0000, 8'h00, 4'b1010, 8'h44, 64'h0033_0000_0011_0000,
               1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(10, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 16'h0011, 2'd1, 1'b0, 5'd2);
        setVec(11, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 16'h0033, 2'd1, 1'b0, 5'd1);
        setVec(12, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(13, 4'b0000, 8'h00, 4'b0001, 8'h03, 64'h0000_0000_0000_0abc,
               1'b0, 16'h0, 2'd0, 1'b0, 5'd0);
        setVec(14, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 16'h0abc, 2'd3, 1'b1, 5'd1);
        setVec(15, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd0);
        setVec(16, 4'b0001, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd0);
        setVec(17, 4'b0000, 8'h00, 4'b0001, 8'h00, 64'h0000_0000_0000_ffff,
               1'b0, 16'h0, 2'd0, 1'b1, 5'd0);
`ifdef PIFO_COLLECT_EMPTY_FILTER_EN
        setVec(18, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd0);
`else
        setVec(18, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b1, 16'hffff, 2'd0, 1'b1, 5'd1);
`endif
        setVec(19, 4'b0000, 8'h00, 4'b0000, 8'h00, 64'h0, 1'b0, 16'h0, 2'd0, 1'b1, 5'd0);

        for (int i = 0; i < NROWS; i++) begin
            applyStimulus(vecs[i]);
            checkFlags($sformatf("row%0d", i), vecs[i].expValid, vecs[i].expCount,
                       vecs[i].expStall, vecs[i].expOverflow, vecs[i].expErr);
            if (vecs[i].expValid) begin
                checkOutput($sformatf("row%0d data", i), 32'(bus.o_data), 32'(vecs[i].expData));
                checkOutput($sformatf("row%0d tree", i), 32'(bus.o_tree_id), 32'(vecs[i].expTree));
            end
        end
        clearInputs();

        // Backpressure threshold: stall when free < tot + LEVEL.
        doReset();
        pushResults(4'hF, 2'd1, 16'h0100);
        pushResults(4'hF, 2'd1, 16'h0110);
        pushResults(4'hF, 2'd1, 16'h0120);
        step();
        checkFlags("bp count12", 1'b1, 5'd12, 1'b0, 1'b0, 1'b1);
        checkOutput("bp head0", 32'(bus.o_data), 32'h0100);
        pushResults(4'b0001, 2'd1, 16'h0130);
        step();
        checkFlags("bp count13", 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);
        bus.i_ready = 1'b1;
        step();
        bus.i_ready = 1'b0;
        checkFlags("bp drain1", 1'b1, 5'd12, 1'b0, 1'b0, 1'b1);
        checkOutput("bp head1", 32'(bus.o_data), 32'h0101);
        bus.i_pop_issue = 4'b0001;
        bus.i_pop_issue_tree_id = '0;
        step();
        clearInputs();
        checkFlags("bp tot1", 1'b1, 5'd12, 1'b1, 1'b0, 1'b1);
        pushResults(4'b0001, 2'd0, 16'h0140);
        step();
        checkFlags("bp tot0 count13", 1'b1, 5'd13, 1'b1, 1'b0, 1'b1);

        // Overflow: fill to 15, then four results, only lane 0 fits.
        doReset();
        pushResults(4'hF,    2'd0, 16'h1000);
        pushResults(4'hF,    2'd0, 16'h1010);
        pushResults(4'hF,    2'd0, 16'h1020);
        pushResults(4'b0111, 2'd0, 16'h1030);
        step();
        checkFlags("ovf count15", 1'b1, 5'd15, 1'b1, 1'b0, 1'b1);
        pushResults(4'hF, 2'd0, 16'h1040);
        step();
        checkFlags("ovf count16", 1'b1, 5'd16, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) begin
            if (i < 15) begin
                expHead = 16'h1000 + 16'((i / 4) * 16) + 16'(i % 4);
            end else begin
                expHead = 16'h1040;
            end
            checkOutput($sformatf("ovf drain%0d data", i), 32'(bus.o_data), 32'(expHead));
            checkOutput($sformatf("ovf drain%0d valid", i), 32'(bus.o_valid), 32'h1);
            bus.i_ready = 1'b1;
            step();
        end
        bus.i_ready = 1'b0;
        checkFlags("ovf empty", 1'b0, 5'd0, 1'b0, 1'b1, 1'b1);

        // Asynchronous reset with an entry still queued.
        pushResults(4'b0001, 2'd2, 16'h2222);
        step();
        checkFlags("pre-reset", 1'b1, 5'd1, 1'b0, 1'b1, 1'b1);
        #2;
        arstN = 1'b0;
        #1;
        checkFlags("async reset", 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        checkOutput("async reset data", 32'(bus.o_data), 32'h0);
        step();
        arstN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
